round_sequencer: RTL and testbench

- Central game-flow controller for the pattern-memory game.
- Replaces the ad-hoc delay/lrst/lpge logic with one explicit FSM.
- Sequences pattern_generator, print_pattern and input_trim each round; pulses their active-low loop reset between rounds.
- Counts rounds and correct answers, adds an optional input timeout, and produces the score for print_score_7seg.

---
 rtl/round_sequencer_if.sv | 21 ++
 rtl/round_sequencer.sv | 121 ++++++++++++
 tb/tb_round_sequencer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/round_sequencer_if.sv
// rtl/round_sequencer_if.sv - handshake bundle between round_sequencer and the per-round sub-blocks
interface round_sequencer_if;
  logic gen_req;
  logic pattern_gen_end;
  logic print_en;
  logic print_pattern_end;
  logic input_en;
  logic input_trim_end;
  logic round_win;
  logic loop_rst_n;

  modport master (
    output gen_req, print_en, input_en, loop_rst_n,
    input  pattern_gen_end, print_pattern_end, input_trim_end, round_win
  );

  modport slave (
    input  gen_req, print_en, input_en, loop_rst_n,
    output pattern_gen_end, print_pattern_end, input_trim_end, round_win
  );
endinterface

// File: rtl/round_sequencer.sv
// rtl/round_sequencer.sv - game-flow FSM: sequences generate/show/entry per round, judges and scores
module round_sequencer #(
  parameter int NUM_ROUNDS    = 10,
  parameter int SETTLE_CYCLES = 4,
  parameter int LRST_CYCLES   = 2,
  parameter int INPUT_TIMEOUT = 0,
  parameter int POINTS        = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                level_valid,
  input  logic [2:0]          level,
  round_sequencer_if.master   sub,
  output logic [2:0]          level_q,
  output logic [3:0]          round_count,
  output logic [3:0]          answer_count,
  output logic [6:0]          score,
  output logic                round_done,
  output logic                game_over
);

  typedef enum logic [2:0] {IDLE, GEN, SHOW, ENTRY, SETTLE, JUDGE, CLEAR, DONE} state_t;

  localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] LRST_LAST    = 16'(LRST_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(INPUT_TIMEOUT - 1);
  localparam logic [3:0]  LAST_ROUND   = 4'(NUM_ROUNDS);

  state_t      state;
  state_t      state_next;
  logic [15:0] cnt;
  logic        level_ok;
  logic        timeout_hit;
  logic        gen_req_d;
  logic        print_en_d;
  logic        input_en_d;
  logic        loop_rst_n_d;
  logic        round_done_d;
  logic        game_over_d;
  logic        judge_win;

  assign level_ok    = level_valid && (level == 3'b001 || level == 3'b010 || level == 3'b100);
  assign timeout_hit = (INPUT_TIMEOUT != 0) && (cnt == TIMEOUT_LAST);

  // cnt restarts on every state change, so it measures time spent in the current state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        cnt <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (level_ok) state_next = GEN;
      // the first GEN cycle is skipped so a completion flag left over from the last round is not trusted
      GEN:     if (cnt != '0 && sub.pattern_gen_end) state_next = SHOW;
      SHOW:    if (sub.print_pattern_end) state_next = ENTRY;
      ENTRY: begin
        if (sub.input_trim_end)   state_next = SETTLE;
        else if (timeout_hit)     state_next = JUDGE;
      end
      SETTLE:  if (cnt == SETTLE_LAST) state_next = JUDGE;
      JUDGE:   state_next = (round_count == LAST_ROUND) ? DONE : CLEAR;
      CLEAR:   if (cnt == LRST_LAST) state_next = GEN;
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // outputs are decoded from the state being entered and registered, so they line up with the state
  always_comb begin
    gen_req_d    = (state_next == GEN) && (state != GEN);
    print_en_d   = (state_next == SHOW) || (state_next == ENTRY) || (state_next == SETTLE);
    input_en_d   = (state_next == ENTRY) || (state_next == SETTLE);
    loop_rst_n_d = (state_next != CLEAR);
    round_done_d = (state_next == JUDGE) && (state != JUDGE);
    game_over_d  = (state_next == DONE);
    judge_win    = sub.round_win && (state == SETTLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub.gen_req    <= 1'b0;
      sub.print_en   <= 1'b0;
      sub.input_en   <= 1'b0;
      sub.loop_rst_n <= 1'b1;
      round_done     <= 1'b0;
      game_over      <= 1'b0;
      level_q        <= 3'b000;
      round_count    <= 4'd0;
      answer_count   <= 4'd0;
      score          <= 7'd0;
    end else begin
      sub.gen_req    <= gen_req_d;
      sub.print_en   <= print_en_d;
      sub.input_en   <= input_en_d;
      sub.loop_rst_n <= loop_rst_n_d;
      round_done     <= round_done_d;
      game_over      <= game_over_d;
      if (state == IDLE && level_ok) begin
        level_q <= level;
      end
      // a round reaching JUDGE straight from ENTRY timed out and never scores
      if (round_done_d) begin
        if (round_count != 4'hF) round_count <= round_count + 4'd1;
        if (judge_win && answer_count != 4'hF) answer_count <= answer_count + 4'd1;
      end
      score <= 7'(int'(answer_count) * POINTS);
    end
  end

endmodule

// File: tb/tb_round_sequencer.sv
// tb/tb_round_sequencer.sv - scoreboard bench for round_sequencer with randomized round stimulus
module tb_round_sequencer;
  localparam int NR = 10;
  localparam int ST = 4;
  localparam int LR = 2;
  localparam int TO = 50;
  localparam int PT = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       level_valid = 1'b0;
  logic [2:0] level = 3'b000;
  logic [2:0] level_q;
  logic [3:0] round_count;
  logic [3:0] answer_count;
  logic [6:0] score;
  logic       round_done;
  logic       game_over;

  round_sequencer_if sif();

  round_sequencer #(
    .NUM_ROUNDS(NR), .SETTLE_CYCLES(ST), .LRST_CYCLES(LR), .INPUT_TIMEOUT(TO), .POINTS(PT)
  ) dut (
    .clk(clk), .rst(rst), .level_valid(level_valid), .level(level), .sub(sif),
    .level_q(level_q), .round_count(round_count), .answer_count(answer_count),
    .score(score), .round_done(round_done), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct { int rc; int ac; } exp_t;
  exp_t sb[$];

  int n_tests = 0;
  int n_fail = 0;
  int gen_cnt = 0;
  int lrun = 0;
  int score_exp = 0;
  bit score_pend = 0;
  bit prev_rd = 0;
  int rounds_started = 0;
  int exp_rounds = 0;
  int exp_wins = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // monitor: pops the scoreboard on every judgement, checks score one cycle later
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      score_pend = 0;
      lrun = 0;
      gen_cnt = 0;
      prev_rd = 0;
    end else begin
      if (score_pend) begin
        chk("score", int'(score), score_exp);
        score_pend = 0;
      end
      if (sif.gen_req) gen_cnt++;
      if (!sif.loop_rst_n) lrun++;
      else if (lrun != 0) begin
        chk("loop_rst_n_low_width", lrun, LR);
        lrun = 0;
      end
      if (round_done) begin
        chk("round_done_pulse_prev", int'(prev_rd), 0);
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_round_done: got round_done with empty scoreboard, expected none");
        end else begin
          e = sb.pop_front();
          chk("round_count", int'(round_count), e.rc);
          chk("answer_count", int'(answer_count), e.ac);
          score_exp = e.ac * PT;
          score_pend = 1;
        end
      end
      prev_rd = round_done;
    end
  end

  task automatic cycles(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int which, input int limit, output int n);
    bit hit;
    n = 0;
    hit = 0;
    while (!hit && n < limit) begin
      @(posedge clk);
      #1;
      n++;
      case (which)
        0:       hit = sif.gen_req || game_over;
        1:       hit = sif.print_en;
        2:       hit = sif.input_en;
        3:       hit = round_done;
        4:       hit = !sif.loop_rst_n || game_over;
        default: hit = 1;
      endcase
    end
    if (!hit) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_%0d: got no event within %0d cycles, expected one", which, limit);
    end
  endtask

  task automatic clear_inputs();
    level_valid = 0;
    sif.pattern_gen_end = 0;
    sif.print_pattern_end = 0;
    sif.input_trim_end = 0;
    sif.round_win = 0;
  endtask

  task automatic start_game(input logic [2:0] lv);
    int n;
    rounds_started = 0;
    exp_rounds = 0;
    exp_wins = 0;
    level = lv;
    level_valid = 1;
    wait_until(0, 5, n);
    level_valid = 0;
  endtask

  // called in the first GEN cycle; trim_at < 0 means no trim (timeout); abort 1=stop mid-SETTLE, 2=stop in CLEAR
  task automatic play_round(input bit win, input int trim_at, input bit stale, input bit hold_gen, input int abort);
    int n;
    rounds_started++;
    if (stale) begin
      cycles(1);
      chk("stale_gen_masked", int'(sif.print_en), 0);
      cycles(1);
      chk("stale_gen_advance", int'(sif.print_en), 1);
    end else begin
      cycles($urandom_range(1, 4));
      sif.pattern_gen_end = 1;
      wait_until(1, 10, n);
    end
    cycles($urandom_range(1, 3));
    sif.print_pattern_end = 1;
    wait_until(2, 10, n);
    chk("gen_req_count", gen_cnt, rounds_started);
    sif.round_win = win;
    exp_rounds++;
    if (win && trim_at >= 0) exp_wins++;
    sb.push_back('{exp_rounds, exp_wins});
    if (trim_at >= 0) begin
      cycles(trim_at);
      sif.input_trim_end = 1;
      if (abort == 1) begin
        cycles(2);
        return;
      end
      wait_until(3, 200, n);
      chk("settle_latency", n, 1 + ST);
    end else begin
      wait_until(3, 200, n);
      chk("timeout_latency", n, TO);
    end
    wait_until(4, 10, n);
    if (abort == 2) return;
    sif.print_pattern_end = 0;
    sif.input_trim_end = 0;
    sif.round_win = 0;
    if (!hold_gen) sif.pattern_gen_end = 0;
    wait_until(0, 10, n);
  endtask

  task automatic async_reset_check(input string tag);
    rst = 1;
    #2;
    chk({tag, "_loop_rst_n"}, int'(sif.loop_rst_n), 1);
    chk({tag, "_round_count"}, int'(round_count), 0);
    chk({tag, "_answer_count"}, int'(answer_count), 0);
    chk({tag, "_score"}, int'(score), 0);
    chk({tag, "_print_en"}, int'(sif.print_en), 0);
    chk({tag, "_input_en"}, int'(sif.input_en), 0);
    clear_inputs();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    cycles(2);
    rst = 0;
  endtask

  initial begin
    bit w[NR];
    int j;
    bit t;
    clear_inputs();
    cycles(2);
    chk("rst_gen_req", int'(sif.gen_req), 0);
    chk("rst_print_en", int'(sif.print_en), 0);
    chk("rst_input_en", int'(sif.input_en), 0);
    chk("rst_loop_rst_n", int'(sif.loop_rst_n), 1);
    chk("rst_round_done", int'(round_done), 0);
    chk("rst_game_over", int'(game_over), 0);
    chk("rst_level_q", int'(level_q), 0);
    chk("rst_score", int'(score), 0);
    rst = 0;
    cycles(1);

    level_valid = 1;
    level = 3'b011; cycles(3);
    level = 3'b000; cycles(3);
    level = 3'b110; cycles(2);
    level_valid = 0;
    cycles(1);
    chk("invalid_level_gen_req", gen_cnt, 0);
    chk("invalid_level_level_q", int'(level_q), 0);
    chk("invalid_level_print_en", int'(sif.print_en), 0);

    // game A: directed corner rounds then random ones
    start_game(3'b001);
    chk("level_q_latched", int'(level_q), 1);
    play_round(1, 5, 0, 0, 0);
    play_round(1, -1, 0, 0, 0);
    play_round(1, TO - 1, 0, 0, 0);
    play_round(0, 3, 0, 1, 0);
    play_round(1, 2, 1, 0, 0);
    level = 3'b100;
    level_valid = 1;
    for (int r = 5; r < NR; r++) play_round(1'($urandom_range(0, 1)), $urandom_range(0, 20), 0, 0, 0);
    level_valid = 0;
    chk("midgame_level_q", int'(level_q), 1);
    chk("gameA_game_over", int'(game_over), 1);
    chk("gameA_round_count", int'(round_count), NR);
    chk("gameA_answer_count", int'(answer_count), exp_wins);
    chk("gameA_score", int'(score), exp_wins * PT);

    // game B: exactly 7 wins in shuffled positions
    do_reset();
    for (int i = 0; i < NR; i++) w[i] = (i < 7);
    for (int i = NR - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = w[i]; w[i] = w[j]; w[j] = t;
    end
    start_game(3'b010);
    for (int i = 0; i < NR; i++) play_round(w[i], $urandom_range(0, 20), 0, 0, 0);
    repeat (40) begin
      @(posedge clk);
      #1;
      level_valid = 1'($urandom);
      level = 3'(1 << $urandom_range(0, 2));
      sif.pattern_gen_end = 1'($urandom);
      sif.print_pattern_end = 1'($urandom);
      sif.input_trim_end = 1'($urandom);
      sif.round_win = 1'($urandom);
    end
    chk("done_gen_req_frozen", gen_cnt, NR);
    chk("done_game_over", int'(game_over), 1);
    chk("done_round_count", int'(round_count), 10);
    chk("done_answer_count", int'(answer_count), 7);
    chk("done_score", int'(score), 70);
    chk("done_level_q", int'(level_q), 2);

    // asynchronous reset mid-SETTLE and mid-CLEAR
    do_reset();
    start_game(3'b100);
    play_round(1, 4, 0, 0, 0);
    play_round(1, 5, 0, 0, 1);
    async_reset_check("rst_settle");
    start_game(3'b001);
    play_round(1, 3, 0, 0, 2);
    async_reset_check("rst_clear");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000 ns, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
